// File: rtl/vcve2_velem_seq.sv
// ---------------------------------------------------------------------------
// vcve2_velem_seq -- vector element sequencer
//
// Accepts one vector operation's configuration and checks it for legality.
// For a legal configuration it walks the elements from vstart to vl-1 and
// issues one element descriptor per valid/ready handshake. Each descriptor
// carries the physical vreg, byte offset, byte enables and element index.
// Handles any power-of-two VLEN, ELEN of 8/16/32 and all legal LMUL values,
// including fractional LMUL.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               configuration valid (sampled only in IDLE)
//   vl_i, vstart_i        vector length, first element index
//   vsew_i, vlmul_i       SEW / LMUL encodings (vlmul 3'b100 reserved)
//   vbase_i               base vreg of the register group
//   flush_i               abort the current sequence
//   busy_o                high in every state except IDLE
//   elem_valid_o/ready_i  descriptor handshake
//   elem_vreg_o           physical vreg of the element
//   elem_boff_o           byte offset of the element inside the vreg
//   elem_be_o             byte enables within a 32-bit word
//   elem_idx_o            element index
//   elem_last_o           element index == vl-1
//   done_o                one-cycle pulse: sequence completed normally
//   err_o                 one-cycle pulse: illegal configuration
// ---------------------------------------------------------------------------
module vcve2_velem_seq #(
    parameter int VLEN      = 128,
    parameter int ELEN      = 32,
    parameter int NUM_VREGS = 32,
    localparam int VL_W     = $clog2(VLEN + 1),
    localparam int BOFF_W   = $clog2(VLEN / 8)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [VL_W-1:0]   vl_i,
    input  logic [VL_W-1:0]   vstart_i,
    input  logic [2:0]        vsew_i,
    input  logic [2:0]        vlmul_i,
    input  logic [4:0]        vbase_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              elem_valid_o,
    input  logic              elem_ready_i,
    output logic [4:0]        elem_vreg_o,
    output logic [BOFF_W-1:0] elem_boff_o,
    output logic [3:0]        elem_be_o,
    output logic [VL_W-1:0]   elem_idx_o,
    output logic              elem_last_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [VL_W-1:0] IDX_ONE = {{(VL_W-1){1'b0}}, 1'b1};

    // Legality of a configuration. VLMAX is formed with shifts only:
    // (VLEN/8 >> sew) scaled up by integer LMUL or down by the fractional
    // denominator.
    function automatic logic cfg_illegal(
        input logic [VL_W-1:0] vl,
        input logic [2:0]      vsew,
        input logic [2:0]      vlmul,
        input logic [4:0]      vbase
    );
        logic             sew_bad;
        logic [6:0]       span;
        logic [4:0]       align_mask;
        logic [VL_W+3:0]  per_reg;
        logic [VL_W+3:0]  vlmax;
        sew_bad = (vsew > 3'd2) || ((32'd8 << vsew) > 32'(ELEN));
        case (vlmul)
            3'd1:    span = 7'd2;
            3'd2:    span = 7'd4;
            3'd3:    span = 7'd8;
            default: span = 7'd1;
        endcase
        // Fractional/unit LMUL has span 1, so the mask is zero and alignment is free.
        align_mask = span[4:0] - 5'd1;
        per_reg    = (VL_W+4)'(VLEN / 8) >> vsew;
        case (vlmul)
            3'd0:    vlmax = per_reg;
            3'd1:    vlmax = per_reg << 1;
            3'd2:    vlmax = per_reg << 2;
            3'd3:    vlmax = per_reg << 3;
            3'd5:    vlmax = per_reg >> 3;
            3'd6:    vlmax = per_reg >> 2;
            3'd7:    vlmax = per_reg >> 1;
            default: vlmax = '0;
        endcase
        return sew_bad
            || (vlmul == 3'b100)
            || ((vbase & align_mask) != 5'd0)
            || (({2'b00, vbase} + span) > 7'(NUM_VREGS))
            || ({4'b0000, vl} > vlmax);
    endfunction

    state_e              state_r;
    logic [VL_W-1:0]     vl_r;
    logic [VL_W-1:0]     vstart_r;
    logic [2:0]          sew_r;
    logic [4:0]          vbase_r;
    logic [VL_W-1:0]     idx_r;
    logic                busy_r;
    logic                valid_r;
    logic [4:0]          vreg_r;
    logic [BOFF_W-1:0]   boff_r;
    logic [3:0]          be_r;
    logic                last_r;
    logic                done_r;
    logic                err_r;

    logic [VL_W-1:0]     desc_idx_s;
    logic [VL_W+1:0]     ba_s;
    logic [4:0]          vreg_s;
    logic [BOFF_W-1:0]   boff_s;
    logic [3:0]          be_s;
    logic                last_s;

    // Descriptor for the next element to present: vstart when leaving CHECK,
    // otherwise the element after the one currently on the outputs.
    always_comb begin
        desc_idx_s = '0;
        if (state_r == ST_CHECK) begin
            desc_idx_s = vstart_r;
        end else begin
            desc_idx_s = idx_r + IDX_ONE;
        end
        ba_s   = {2'b00, desc_idx_s} << sew_r[1:0];
        vreg_s = vbase_r + 5'(ba_s >> BOFF_W);
        boff_s = ba_s[BOFF_W-1:0];
        case (sew_r[1:0])
            2'b00:   be_s = 4'b0001 << ba_s[1:0];
            2'b01:   be_s = 4'b0011 << ba_s[1:0];
            default: be_s = 4'b1111;
        endcase
        last_s = (desc_idx_s == (vl_r - IDX_ONE));
    end

    // Sequencer FSM with registered outputs. err is raised on the edge that
    // enters CHECK so that it is visible during the CHECK cycle itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r  <= ST_IDLE;
            vl_r     <= '0;
            vstart_r <= '0;
            sew_r    <= 3'd0;
            vbase_r  <= 5'd0;
            idx_r    <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            vreg_r   <= 5'd0;
            boff_r   <= '0;
            be_r     <= 4'd0;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
        end else if (flush_i) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            vreg_r  <= 5'd0;
            boff_r  <= '0;
            be_r    <= 4'd0;
            idx_r   <= '0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        vl_r     <= vl_i;
                        vstart_r <= vstart_i;
                        sew_r    <= vsew_i;
                        vbase_r  <= vbase_i;
                        err_r    <= cfg_illegal(vl_i, vsew_i, vlmul_i, vbase_i);
                        busy_r   <= 1'b1;
                        state_r  <= ST_CHECK;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (err_r) begin
                        err_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else if (vstart_r >= vl_r) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        valid_r <= 1'b1;
                        idx_r   <= desc_idx_s;
                        vreg_r  <= vreg_s;
                        boff_r  <= boff_s;
                        be_r    <= be_s;
                        last_r  <= last_s;
                        state_r <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (elem_ready_i && last_r) begin
                        valid_r <= 1'b0;
                        vreg_r  <= 5'd0;
                        boff_r  <= '0;
                        be_r    <= 4'd0;
                        idx_r   <= '0;
                        last_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (elem_ready_i) begin
                        idx_r   <= desc_idx_s;
                        vreg_r  <= vreg_s;
                        boff_r  <= boff_s;
                        be_r    <= be_s;
                        last_r  <= last_s;
                    end else begin
                        state_r <= ST_ISSUE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    valid_r <= 1'b0;
                    done_r  <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o       = busy_r;
    assign elem_valid_o = valid_r;
    assign elem_vreg_o  = vreg_r;
    assign elem_boff_o  = boff_r;
    assign elem_be_o    = be_r;
    assign elem_idx_o   = idx_r;
    assign elem_last_o  = last_r;
    assign done_o       = done_r;
    assign err_o        = err_r;

endmodule

// File: tb/tb_vcve2_velem_seq.sv
// Directed self-checking bench for vcve2_velem_seq (VLEN=128, ELEN=32).
module tb_vcve2_velem_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       flush = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] vl = 8'd0;
    logic [7:0] vstart = 8'd0;
    logic [2:0] vsew = 3'd0;
    logic [2:0] vlmul = 3'd0;
    logic [4:0] vbase = 5'd0;

    logic       busy, valid, last, done, err;
    logic [4:0] vreg;
    logic [3:0] boff;
    logic [3:0] be;
    logic [7:0] idx;

    int checks = 0;
    int errors = 0;

    vcve2_velem_seq #(.VLEN(128), .ELEN(32), .NUM_VREGS(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .vl_i(vl), .vstart_i(vstart), .vsew_i(vsew), .vlmul_i(vlmul),
        .vbase_i(vbase), .flush_i(flush), .busy_o(busy),
        .elem_valid_o(valid), .elem_ready_i(ready), .elem_vreg_o(vreg),
        .elem_boff_o(boff), .elem_be_o(be), .elem_idx_o(idx),
        .elem_last_o(last), .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    wire [25:0] obs = {busy, valid, vreg, boff, be, idx, last, done, err};
    wire [3:0]  ctl = {busy, valid, done, err};

    // Expected full output vector for a cycle in which a descriptor is shown.
    function automatic logic [25:0] desc(input logic [4:0] r, input logic [3:0] o,
                                         input logic [3:0] b, input logic [7:0] i,
                                         input logic l);
        return {1'b1, 1'b1, r, o, b, i, l, 1'b0, 1'b0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a configuration with start high for one cycle (cycle T);
    // returns during cycle T+1.
    task automatic start_cfg(input logic [7:0] l, input logic [7:0] vs,
                             input logic [2:0] s, input logic [2:0] m,
                             input logic [4:0] b);
        vl = l; vstart = vs; vsew = s; vlmul = m; vbase = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (obs !== 26'd0) begin errors++; $display("FAIL reset_async got %h want %h", obs, 26'd0); end
        step(); step();
        rst = 1'b0;
        step();
        checks++;
        if (obs !== 26'd0) begin errors++; $display("FAIL reset_idle got %h want %h", obs, 26'd0); end
    endtask

    task automatic test_sew32_lmul1();
        start_cfg(8'd4, 8'd0, 3'd2, 3'd0, 5'd2);
        checks++;
        if (ctl !== 4'b1000) begin errors++; $display("FAIL s32_check got %b want %b", ctl, 4'b1000); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (obs !== desc(5'd2, 4'(4 * i), 4'hF, 8'(i), i == 3)) begin
                errors++;
                $display("FAIL s32_elem%0d got %h want %h", i, obs, desc(5'd2, 4'(4 * i), 4'hF, 8'(i), i == 3));
            end
        end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL s32_done got %b want %b", ctl, 4'b1010); end
        step();
        checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL s32_idle got %b want %b", ctl, 4'b0000); end
    endtask

    task automatic test_sew8_lmul2();
        logic [25:0] e;
        start_cfg(8'd20, 8'd0, 3'd0, 3'd1, 5'd4);
        for (int i = 0; i < 20; i++) begin
            step();
            e = desc(5'd4 + 5'(i / 16), 4'(i % 16), 4'b0001 << (i % 4), 8'(i), i == 19);
            if (i == 15) e = desc(5'd4, 4'd15, 4'h8, 8'd15, 1'b0);
            if (i == 16) e = desc(5'd5, 4'd0, 4'h1, 8'd16, 1'b0);
            checks++;
            if (obs !== e) begin errors++; $display("FAIL s8_elem%0d got %h want %h", i, obs, e); end
        end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL s8_done got %b want %b", ctl, 4'b1010); end
        step();
    endtask

    task automatic test_illegal();
        logic [7:0] l_t [4] = '{8'd1, 8'd5, 8'd1, 8'd1};
        logic [2:0] s_t [4] = '{3'd0, 3'd2, 3'd0, 3'd7};
        logic [2:0] m_t [4] = '{3'd1, 3'd0, 3'd4, 3'd0};
        logic [4:0] b_t [4] = '{5'd3, 5'd0, 5'd0, 5'd0};
        for (int k = 0; k < 4; k++) begin
            start_cfg(l_t[k], 8'd0, s_t[k], m_t[k], b_t[k]);
            checks++;
            if (ctl !== 4'b1001) begin errors++; $display("FAIL illegal%0d_err got %b want %b", k, ctl, 4'b1001); end
            step();
            checks++;
            if (ctl !== 4'b0000) begin errors++; $display("FAIL illegal%0d_after got %b want %b", k, ctl, 4'b0000); end
        end
    endtask

    task automatic test_vstart_tail();
        start_cfg(8'd4, 8'd3, 3'd1, 3'd0, 5'd0);
        step();
        checks++;
        if (obs !== desc(5'd0, 4'd6, 4'hC, 8'd3, 1'b1)) begin
            errors++; $display("FAIL tail_elem got %h want %h", obs, desc(5'd0, 4'd6, 4'hC, 8'd3, 1'b1));
        end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL tail_done got %b want %b", ctl, 4'b1010); end
        step();
    endtask

    task automatic test_vstart_ge_vl();
        start_cfg(8'd4, 8'd4, 3'd2, 3'd0, 5'd0);
        checks++;
        if (ctl !== 4'b1000) begin errors++; $display("FAIL skip_t1 got %b want %b", ctl, 4'b1000); end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL skip_t2 got %b want %b", ctl, 4'b1010); end
        step();
        checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL skip_idle got %b want %b", ctl, 4'b0000); end
    endtask

    task automatic test_ready_toggle();
        start_cfg(8'd4, 8'd0, 3'd2, 3'd0, 5'd0);
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (obs !== desc(5'd0, 4'(4 * (c / 2)), 4'hF, 8'(c / 2), (c / 2) == 3)) begin
                errors++;
                $display("FAIL stall_c%0d got %h want %h", c, obs, desc(5'd0, 4'(4 * (c / 2)), 4'hF, 8'(c / 2), (c / 2) == 3));
            end
            ready = (c % 2 == 1);
        end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL stall_done got %b want %b", ctl, 4'b1010); end
        ready = 1'b1;
        step();
    endtask

    task automatic test_flush();
        start_cfg(8'd4, 8'd0, 3'd2, 3'd0, 5'd2);
        step();
        step();
        checks++;
        if (obs !== desc(5'd2, 4'd4, 4'hF, 8'd1, 1'b0)) begin
            errors++; $display("FAIL flush_elem1 got %h want %h", obs, desc(5'd2, 4'd4, 4'hF, 8'd1, 1'b0));
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL flush_idle got %b want %b", ctl, 4'b0000); end
        start_cfg(8'd4, 8'd4, 3'd2, 3'd0, 5'd0);
        checks++;
        if (ctl !== 4'b1000) begin errors++; $display("FAIL flush_restart got %b want %b", ctl, 4'b1000); end
        step();
        checks++;
        if (ctl !== 4'b1010) begin errors++; $display("FAIL flush_redone got %b want %b", ctl, 4'b1010); end
        step();
    endtask

    task automatic test_rst_mid();
        start_cfg(8'd4, 8'd0, 3'd2, 3'd0, 5'd2);
        step();
        step();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 26'd0) begin errors++; $display("FAIL rst_mid got %h want %h", obs, 26'd0); end
        step();
        rst = 1'b0;
        step();
        checks++;
        if (ctl !== 4'b0000) begin errors++; $display("FAIL rst_after got %b want %b", ctl, 4'b0000); end
    endtask

    initial begin
        test_reset();
        test_sew32_lmul1();
        test_sew8_lmul2();
        test_illegal();
        test_vstart_tail();
        test_vstart_ge_vl();
        test_ready_toggle();
        test_flush();
        test_rst_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
